// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobing, whole-scan debounce and single-key press events.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 8,
    parameter int unsigned REPEAT_DELAY   = 60,
    parameter int unsigned REPEAT_RATE    = 15
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned SlotW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MatchW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SlotW-1:0]  SlotLast = SlotW'(SCAN_DIV - 1);
    localparam logic [MatchW-1:0] MatchMax = MatchW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_param_check
        $error("keypad_scan: illegal parameter value");
    end

    typedef enum logic [1:0] {StRow0, StRow1, StRow2, StRow3} row_state_e;

    row_state_e        state_q, state_d;
    logic [SlotW-1:0]  slot_q;
    logic [3:0]        col_meta_q, col_sync_q;
    logic [15:0]       snap_q, snap_d, prev_q, stable_q, stable_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d, key_down_q;
    logic              last_slot, scan_end, accept, press, repeat_hit;

    function automatic logic [3:0] bit_index(input logic [15:0] v);
        bit_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) bit_index = 4'(i);
        end
    endfunction

    // Idle columns read high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRow0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= last_slot ? '0 : slot_q + SlotW'(1);
        end
    end

    assign last_slot = (slot_q == SlotLast);
    assign scan_end  = last_slot && (state_q == StRow3);

    always_comb begin
        state_d = state_q;
        row     = 4'b1111;
        if (last_slot) state_d = row_state_e'(state_q + 2'd1);
        unique case (state_q)
            StRow0: row = 4'b1110;
            StRow1: row = 4'b1101;
            StRow2: row = 4'b1011;
            StRow3: row = 4'b0111;
        endcase
    end

    // snap_d already holds the ROW3 sample on scan end, so the compare sees the full scan.
    always_comb begin
        snap_d = snap_q;
        if (last_slot) snap_d[{state_q, 2'b00} +: 4] = ~col_sync_q;
    end

    always_comb begin
        match_d = match_q;
        if (scan_end) begin
            if (snap_d == prev_q) begin
                if (match_q != MatchMax) match_d = match_q + MatchW'(1);
            end else begin
                match_d = MatchW'(1);
            end
        end
    end

    assign accept   = scan_end && (match_d == MatchMax);
    assign stable_d = accept ? snap_d : stable_q;
    assign press    = accept && (stable_q == '0) && $onehot(snap_d);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned HoldW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [HoldW-1:0] HoldDelay = HoldW'(REPEAT_DELAY);
    localparam logic [HoldW-1:0] HoldWrap  = HoldW'(REPEAT_DELAY + REPEAT_RATE);

    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             armed_q, armed_d;

    // Only a key that was announced by a press event may repeat.
    always_comb begin
        hold_d     = hold_q;
        armed_d    = armed_q;
        repeat_hit = 1'b0;
        hold_inc   = hold_q + HoldW'(1);
        if (scan_end) begin
            if (stable_d != stable_q) begin
                hold_d  = '0;
                armed_d = press;
            end else if (armed_q) begin
                if (hold_inc == HoldWrap) begin
                    hold_d     = HoldDelay;
                    repeat_hit = 1'b1;
                end else begin
                    hold_d     = hold_inc;
                    repeat_hit = (hold_inc == HoldDelay);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign key_valid_d = press || repeat_hit;
    assign key_code_d  = press ? bit_index(snap_d) : key_code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q      <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            match_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            if (scan_end) prev_q <= snap_d;
            stable_q    <= stable_d;
            match_q     <= match_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= |stable_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_down;
    logic [15:0] pressed = '0;

    int          checks = 0, failures = 0;
    int          cyc = 0, strobes = 0, last_cyc = -1;
    logic [3:0]  last_code = '0;
    logic [3:0]  exp_row;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY  (4),
        .REPEAT_RATE   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_valid === 1'b1) begin
                strobes++;
                last_code = key_code;
                last_cyc  = cyc;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        cyc      = 0;
        strobes  = 0;
        last_cyc = -1;
    endtask

    initial begin
        // Reset values and idle row rotation
        #1 rst = 1'b1;
        #1;
        chk("rst_row", 16'(row), 16'hE);
        chk("rst_code", 16'(key_code), 16'h0);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_down", 16'(key_down), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 64; k++) begin
            tick(1);
            exp_row = 4'b1111 ^ (4'b0001 << ((cyc / 4) % 4));
            chk("idle_row", 16'(row), 16'(exp_row));
        end
        chk("idle_strobes", 16'(strobes), 16'd0);
        chk("idle_down", 16'(key_down), 16'h0);

        // Key 9 held from cycle 0, then released
        reset_dut();
        pressed[9] = 1'b1;
        tick(47);
        chk("k9_early", 16'(strobes), 16'd0);
        tick(1);
        chk("k9_strobes", 16'(strobes), 16'd1);
        chk("k9_code", 16'(last_code), 16'd9);
        chk("k9_cycle", 16'(last_cyc), 16'd48);
        chk("k9_down", 16'(key_down), 16'h1);
        pressed = '0;
        tick(47);
        chk("k9_down_held", 16'(key_down), 16'h1);
        tick(1);
        chk("k9_down_fall", 16'(key_down), 16'h0);
        chk("k9_one_strobe", 16'(strobes), 16'd1);

        // Key 9 toggled on alternate scans, then held
        reset_dut();
        for (int s = 0; s < 10; s++) begin
            pressed[9] = (s % 2 == 0);
            tick(16);
        end
        chk("bounce_none", 16'(strobes), 16'd0);
        pressed[9] = 1'b1;
        tick(47);
        chk("bounce_early", 16'(strobes), 16'd0);
        tick(1);
        chk("bounce_strobe", 16'(strobes), 16'd1);
        chk("bounce_code", 16'(last_code), 16'd9);
        chk("bounce_cycle", 16'(last_cyc), 16'd208);

        // Keys 0 and 15 together, release 15, then release 0
        pressed = '0;
        reset_dut();
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        tick(64);
        chk("multi_none", 16'(strobes), 16'd0);
        chk("multi_down", 16'(key_down), 16'h1);
        pressed[15] = 1'b0;
        tick(64);
        chk("two_to_one_none", 16'(strobes), 16'd0);
        chk("two_to_one_down", 16'(key_down), 16'h1);
        chk("multi_code_hold", 16'(key_code), 16'h0);
        pressed[0] = 1'b0;
        tick(47);
        chk("multi_down_held", 16'(key_down), 16'h1);
        tick(1);
        chk("multi_down_fall", 16'(key_down), 16'h0);
        chk("multi_end_none", 16'(strobes), 16'd0);

        // Reset mid-ROW2 while key 5 is being debounced
        reset_dut();
        pressed[5] = 1'b1;
        tick(25);
        chk("pre_rst_row", 16'(row), 16'hB);
        #2 rst = 1'b1;
        #1;
        chk("async_row", 16'(row), 16'hE);
        chk("async_valid", 16'(key_valid), 16'h0);
        chk("async_down", 16'(key_down), 16'h0);
        chk("async_code", 16'(key_code), 16'h0);
        @(negedge clk);
        rst      = 1'b0;
        cyc      = 0;
        strobes  = 0;
        last_cyc = -1;
        tick(47);
        chk("k5_early", 16'(strobes), 16'd0);
        tick(1);
        chk("k5_strobes", 16'(strobes), 16'd1);
        chk("k5_code", 16'(last_code), 16'd5);
        chk("k5_cycle", 16'(last_cyc), 16'd48);

        // Key 3 held for 12 scans
        pressed = '0;
        reset_dut();
        pressed[3] = 1'b1;
        tick(48);
        chk("k3_strobes", 16'(strobes), 16'd1);
        chk("k3_code", 16'(last_code), 16'd3);
        chk("k3_cycle", 16'(last_cyc), 16'd48);
`ifdef KEYPAD_REPEAT_EN
        tick(64);
        chk("rep1_count", 16'(strobes), 16'd2);
        chk("rep1_cycle", 16'(last_cyc), 16'd112);
        tick(32);
        chk("rep2_count", 16'(strobes), 16'd3);
        chk("rep2_cycle", 16'(last_cyc), 16'd144);
        tick(32);
        chk("rep3_count", 16'(strobes), 16'd4);
        chk("rep3_cycle", 16'(last_cyc), 16'd176);
        chk("rep3_code", 16'(last_code), 16'd3);
`else
        tick(128);
        chk("hold_no_repeat", 16'(strobes), 16'd1);
        chk("hold_code", 16'(key_code), 16'd3);
`endif
        chk("hold_down", 16'(key_down), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment digit driver. It drives one keypad row low at a time and samples the four column lines, building a full 16-key snapshot per scan. Snapshots are debounced across whole scans, and each new single-key press is reported as a 4-bit key code with a one-cycle strobe. It sits between the board keypad pins and the application logic (e.g. timer digit entry), in place of per-button debounce instances.

## Interface
- SCAN_DIV, 1000: clock cycles each row is driven; must be ≥ 4.
- DEBOUNCE_SCANS, 8: consecutive identical full scans required before a snapshot is accepted; must be ≥ 1.
- REPEAT_DELAY, 60: scans a key is held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 15: scans between subsequent auto-repeats (used only with KEYPAD_REPEAT_EN).

- clk  in  1  system clock (the synchronised board clock).
- rst  in  1  reset; asynchronous, active-high.
- row  out  4  row drive, active-low one-hot; row[i]=0 selects row i.
- col  in  4  column sense, active-low (pulled up on board), asynchronous to clk.
- key_code  out  4  code of the last reported key = row*4 + col.
- key_valid  out  1  one-cycle strobe; key_code is valid in the same cycle.
- key_down  out  1  level; high while the accepted snapshot has any key down.

## Operation
- col passes through a 2-flop synchroniser inside the block before any use.
- Row FSM, states ROW0..ROW3 in fixed order, wrapping ROW3→ROW0. Each state lasts exactly SCAN_DIV cycles, and row drives that state's pattern: ROW0=1110, ROW1=1101, ROW2=1011, ROW3=0111.
- Sampling: on the last cycle of each row slot, the inverted synchronised col is written into snapshot bits [row*4+3 : row*4].
- Scan end is the last cycle of ROW3. At scan end, the completed snapshot is compared with the previous scan's snapshot.
  - Equal: the match counter increments, saturating at DEBOUNCE_SCANS.
  - Different: the match counter clears to 1.
- Acceptance: when the match counter reaches DEBOUNCE_SCANS, stable is updated to the snapshot.
- Press event: stable changes from all-zero to exactly one bit set. key_code is set to that bit's index and key_valid pulses once.
- Multiple keys: a stable snapshot with ≥2 bits set produces no event. key_down is still 1. No further event occurs until stable returns to all-zero.
- Going from one key to two keys, or from two keys to one, produces no event.
- key_down = |stable (registered).
- key_code holds its last value between events.

## Timing
- Reset values:
  - row=1110 (ROW0); slot counter 0.
  - snapshot, previous snapshot and stable all 0; match counter 0.
  - key_code=0, key_valid=0, key_down=0.
- Scan period is 4*SCAN_DIV cycles.
- Column settle time is SCAN_DIV-1 cycles from row change to sample, less the 2-cycle sync latency.
- key_valid and the new key_code are registered outputs, appearing 1 cycle after the accepting scan-end cycle.
- Press latency, for a key held clean from the start of scan N: accepted at the end of scan N+DEBOUNCE_SCANS-1; key_valid 1 cycle later.
- A bounce that alters any snapshot bit restarts the count. A key pressed mid-scan may be partial in the first scan; that scan is counted as different.
- rst asserted mid-scan aborts immediately: all state returns to reset values and no strobe is issued. After release, scanning restarts at ROW0.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While stable holds the same single key, a hold counter counts scans.
  - key_valid re-pulses with the same key_code after REPEAT_DELAY scans, then every REPEAT_RATE scans.
  - The hold counter clears on any stable change.
- Not defined: the hold logic and the REPEAT_* parameters are unused; exactly one strobe per press.

## Test plan
(SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles.)
- Reset, no keys for 64 cycles → row cycles 1110,1101,1011,0111 every 4 cycles; key_valid never high; key_down=0.
- Key row 2 / col 1 (col[1]=0 while row=1011) held from cycle 0 → exactly one key_valid with key_code=9 at cycle 48 (the cycle after the third scan end); key_down=1 until 3 clean scans after release.
- Same key toggled on alternate scans for 10 scans, then held → no strobe during toggling; one strobe 3 scans after toggling stops.
- Keys 0 and 15 pressed together, then 15 released → no strobe at any point; key_down=1 throughout; release of key 0 → key_down falls.
- rst pulsed mid-ROW2 during debounce of key 5 → outputs return to reset values asynchronously; key 5 still held after release gives a strobe 3 full scans later.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, key 3 held for 12 scans → strobes at acceptance, then 4, 6 and 8 scans later, all with key_code=3.
